otter_intc: RTL and testbench
=============================

OTTER_INTC -- requirements
Module: otter_intc

Interface
REQ-001 The block SHALL have parameter BASE_AD, default 32'h11100000, giving the base address of the controller's MMIO window.
REQ-002 The block SHALL have parameter NUM_SRC, default 4, range 1..8, giving the number of interrupt sources.
REQ-003 The block SHALL have parameter TIMEOUT, default 1024, giving the re-issue interval in clock cycles.
REQ-004 The block SHALL have port CLK  in  1  system clock; all logic is on the rising edge.
REQ-005 The block SHALL have port RST  in  1  reset; one clock; reset is synchronous and active-high.
REQ-006 The block SHALL have port SRC  in  NUM_SRC  interrupt source levels, already synchronous to CLK.
REQ-007 The block SHALL have port IOBUS_ADDR  in  32  MCU bus address.
REQ-008 The block SHALL have port IOBUS_OUT  in  32  MCU write data.
REQ-009 The block SHALL have port IOBUS_WR  in  1  MCU write strobe.
REQ-010 The block SHALL have port IOBUS_RD_DATA  out  32  read data, to be muxed into the MCU's IOBUS_IN.
REQ-011 The block SHALL have port INTR  out  1  one-cycle interrupt pulse to the MCU's intr input.

Function
REQ-012 The register map SHALL be: ENABLE at BASE_AD+0 (R/W); PENDING at +4 (R, write-1-to-clear); ID at +8 (R, in-service source index); ACK at +C (W); STATUS at +10 (R).
REQ-013 IOBUS_RD_DATA SHALL be combinational from IOBUS_ADDR, zero-extended, and 0 for any unmapped address.
REQ-014 A rising edge on SRC[i] (current 1, previous cycle 0) SHALL set PENDING[i] on the following clock edge.
REQ-015 If a PENDING set and a write-1-to-clear hit the same bit in the same cycle, the set SHALL win.
REQ-016 The FSM SHALL have exactly three states: IDLE, FIRE and WAIT_ACK.
REQ-017 IDLE -> FIRE SHALL occur when (PENDING & ENABLE) != 0. On that transition the block SHALL latch ID with the lowest set index.
REQ-018 In FIRE, INTR SHALL be 1 for exactly one cycle; the next state SHALL be WAIT_ACK. INTR SHALL be 0 in all other states.
REQ-019 In WAIT_ACK, a write to ACK with IOBUS_OUT[2:0] == ID SHALL clear PENDING[ID] and return the FSM to IDLE.
REQ-020 An ACK write with a mismatched ID, or an ACK write outside WAIT_ACK, SHALL be ignored.
REQ-021 Clearing ENABLE[ID] or PENDING[ID] during WAIT_ACK SHALL NOT leave WAIT_ACK; only a matching ACK (or reset) exits it.
REQ-022 The latency from SRC rising edge to INTR SHALL be 3 cycles: pending, IDLE->FIRE, then pulse.
REQ-023 There SHALL be at least one IDLE cycle between successive INTR pulses.
REQ-024 STATUS SHALL be {28'b0, in_service, state[1:0], any_enabled_pending}, where in_service = (state == WAIT_ACK).

Reset
REQ-025 On RST the block SHALL force: ENABLE=0, PENDING=0, ID=0, previous-SRC register=0, FSM=IDLE, INTR=0, timeout counter=0.
REQ-026 A reset asserted mid-operation (in FIRE or WAIT_ACK) SHALL abandon the in-service interrupt with no pulse on the next cycle.
REQ-027 A source held high through reset SHALL NOT set PENDING until it falls and rises again.

Configuration
REQ-028 When OTTER_INTC_TIMEOUT_EN is defined, a counter SHALL run in WAIT_ACK and, after TIMEOUT cycles with no matching ACK, the FSM SHALL return to FIRE for a re-pulse with the same ID and then zero the counter.
REQ-029 When OTTER_INTC_TIMEOUT_EN is undefined, no counter SHALL exist and WAIT_ACK SHALL wait indefinitely.

Structure
REQ-030 Package otter_intc_pkg SHALL hold the register offset constants, the FSM state enum, and the STATUS field positions.
REQ-031 Per-source edge detection and pending-bit logic SHALL be sub-module otter_intc_edge, instantiated NUM_SRC times.

Verification
REQ-032 Bench case: ENABLE=4'b0101; pulse SRC[2] -> INTR high exactly 3 cycles later, ID reads 2, PENDING reads 4'b0100.
REQ-033 Bench case: SRC[3] and SRC[1] rise together with ENABLE=4'hF -> ID=1 is serviced first; after ACK=1, ID=3 is serviced after one IDLE cycle.
REQ-034 Bench case: write ACK=0 while ID=2 -> stays in WAIT_ACK and PENDING unchanged; write ACK=2 -> IDLE and PENDING[2]=0.
REQ-035 Bench case: write PENDING=4'b0001 in the same cycle SRC[0] rises -> PENDING[0] remains 1.
REQ-036 Bench case: assert RST for one cycle while in WAIT_ACK -> all registers read 0, INTR stays 0, STATUS=0.
REQ-037 Bench case: with OTTER_INTC_TIMEOUT_EN defined and TIMEOUT=16, no ACK -> INTR re-pulses every 18 cycles (16 wait + FIRE + the FIRE->WAIT_ACK transition) with unchanged ID.

Source files
------------

// File: rtl/otter_intc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : otter_intc_pkg
//  Description : Register offsets, FSM state type and STATUS field positions
//                shared by the OTTER interrupt controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package otter_intc_pkg;

    localparam logic [31:0] C_OFF_ENABLE  = 32'h0000_0000;
    localparam logic [31:0] C_OFF_PENDING = 32'h0000_0004;
    localparam logic [31:0] C_OFF_ID      = 32'h0000_0008;
    localparam logic [31:0] C_OFF_ACK     = 32'h0000_000C;
    localparam logic [31:0] C_OFF_STATUS  = 32'h0000_0010;

    localparam int C_STAT_ANY       = 0;
    localparam int C_STAT_STATE_LSB = 1;
    localparam int C_STAT_STATE_MSB = 2;
    localparam int C_STAT_INSVC     = 3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FIRE     = 2'd1,
        ST_WAIT_ACK = 2'd2
    } state_t;

    // Scanning downward leaves the lowest set index as the final result.
    function automatic logic [2:0] lowest_index(input logic [7:0] v);
        lowest_index = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) lowest_index = 3'(i);
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/otter_intc_edge.sv
`default_nettype none
// ============================================================================
//  Module      : otter_intc_edge
//  Description : One interrupt source: rising-edge detector and pending bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module otter_intc_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_src,
    input  logic i_clr,
    output logic o_pending
);

    logic r_prev;
    logic r_armed;
    logic r_pending;
    logic w_rise;

    // A source high through reset stays disarmed until it is seen low.
    assign w_rise    = i_src & ~r_prev & r_armed;
    assign o_pending = r_pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev    <= 1'b0;
            r_armed   <= ~i_src;
            r_pending <= 1'b0;
        end else begin
            r_prev  <= i_src;
            r_armed <= r_armed | ~i_src;
            if (w_rise) begin
                r_pending <= 1'b1;
            end else if (i_clr) begin
                r_pending <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/otter_intc.sv
`default_nettype none
// ============================================================================
//  Module      : otter_intc
//  Description : MMIO interrupt controller for the OTTER MCU. Optional
//                re-issue timeout enabled by defining OTTER_INTC_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module otter_intc
    import otter_intc_pkg::*;
#(
    parameter logic [31:0] BASE_AD = 32'h1110_0000,
    parameter int          NUM_SRC = 4,
    parameter int          TIMEOUT = 1024
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NUM_SRC-1:0] SRC,
    input  logic [31:0]        IOBUS_ADDR,
    input  logic [31:0]        IOBUS_OUT,
    input  logic               IOBUS_WR,
    output logic [31:0]        IOBUS_RD_DATA,
    output logic               INTR
);

    state_t             r_state;
    state_t             w_next_state;
    logic [NUM_SRC-1:0] r_enable;
    logic [NUM_SRC-1:0] w_pending;
    logic [NUM_SRC-1:0] w_clr;
    logic [NUM_SRC-1:0] w_req;
    logic [7:0]         w_req8;
    logic [2:0]         r_id;
    logic               r_intr;
    logic               w_any;
    logic               w_wr_enable;
    logic               w_wr_pending;
    logic               w_wr_ack;
    logic               w_ack_hit;
    logic               w_timeout;
    logic               w_unused_wdata;

    assign w_wr_enable  = IOBUS_WR && (IOBUS_ADDR == BASE_AD + C_OFF_ENABLE);
    assign w_wr_pending = IOBUS_WR && (IOBUS_ADDR == BASE_AD + C_OFF_PENDING);
    assign w_wr_ack     = IOBUS_WR && (IOBUS_ADDR == BASE_AD + C_OFF_ACK);
    assign w_ack_hit    = w_wr_ack && (r_state == ST_WAIT_ACK) && (IOBUS_OUT[2:0] == r_id);
    assign w_unused_wdata = ^IOBUS_OUT;

    assign w_req = w_pending & r_enable;
    assign w_any = |w_req;
    assign INTR  = r_intr;

    always_comb begin
        w_req8 = 8'd0;
        w_req8[NUM_SRC-1:0] = w_req;
    end

    generate
        for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
            assign w_clr[i] = (w_wr_pending && IOBUS_OUT[i]) || (w_ack_hit && (r_id == 3'(i)));
            otter_intc_edge u_edge (
                .clk       (CLK),
                .rst       (RST),
                .i_src     (SRC[i]),
                .i_clr     (w_clr[i]),
                .o_pending (w_pending[i])
            );
        end
    endgenerate

`ifdef OTTER_INTC_TIMEOUT_EN
    localparam int c_CNT_W = $clog2(TIMEOUT + 1);
    logic [c_CNT_W-1:0] r_cnt;

    assign w_timeout = (r_cnt == c_CNT_W'(TIMEOUT));

    // Counter only runs while waiting; it restarts from zero on every re-pulse.
    always_ff @(posedge CLK) begin
        if (RST || (r_state != ST_WAIT_ACK) || w_timeout) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT > 0);
    assign w_timeout        = 1'b0;
`endif

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:     if (w_any) w_next_state = ST_FIRE;
            ST_FIRE:     w_next_state = ST_WAIT_ACK;
            ST_WAIT_ACK: begin
                if (w_ack_hit) begin
                    w_next_state = ST_IDLE;
                end else if (w_timeout) begin
                    w_next_state = ST_FIRE;
                end
            end
            default:     w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= ST_IDLE;
            r_enable <= '0;
            r_id     <= 3'd0;
            r_intr   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_intr  <= (r_state == ST_FIRE);
            if (w_wr_enable) begin
                r_enable <= IOBUS_OUT[NUM_SRC-1:0];
            end
            if ((r_state == ST_IDLE) && w_any) begin
                r_id <= lowest_index(w_req8);
            end
        end
    end

    always_comb begin
        IOBUS_RD_DATA = 32'd0;
        if (IOBUS_ADDR == BASE_AD + C_OFF_ENABLE) begin
            IOBUS_RD_DATA[NUM_SRC-1:0] = r_enable;
        end else if (IOBUS_ADDR == BASE_AD + C_OFF_PENDING) begin
            IOBUS_RD_DATA[NUM_SRC-1:0] = w_pending;
        end else if (IOBUS_ADDR == BASE_AD + C_OFF_ID) begin
            IOBUS_RD_DATA[2:0] = r_id;
        end else if (IOBUS_ADDR == BASE_AD + C_OFF_STATUS) begin
            IOBUS_RD_DATA[C_STAT_ANY]                         = w_any;
            IOBUS_RD_DATA[C_STAT_STATE_MSB:C_STAT_STATE_LSB]  = r_state;
            IOBUS_RD_DATA[C_STAT_INSVC]                       = (r_state == ST_WAIT_ACK);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_otter_intc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_otter_intc
//  Description : Directed self-checking bench for otter_intc (NUM_SRC=4).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_otter_intc;

    localparam logic [31:0] c_BASE = 32'h1110_0000;
    localparam logic [31:0] c_A_EN   = c_BASE + 32'h00;
    localparam logic [31:0] c_A_PEND = c_BASE + 32'h04;
    localparam logic [31:0] c_A_ID   = c_BASE + 32'h08;
    localparam logic [31:0] c_A_ACK  = c_BASE + 32'h0C;
    localparam logic [31:0] c_A_STAT = c_BASE + 32'h10;

    logic        CLK = 1'b0;
    logic        RST;
    logic [3:0]  SRC;
    logic [31:0] IOBUS_ADDR;
    logic [31:0] IOBUS_OUT;
    logic        IOBUS_WR;
    logic [31:0] IOBUS_RD_DATA;
    logic        INTR;

    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    otter_intc #(.BASE_AD(c_BASE), .NUM_SRC(4), .TIMEOUT(16)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .SRC           (SRC),
        .IOBUS_ADDR    (IOBUS_ADDR),
        .IOBUS_OUT     (IOBUS_OUT),
        .IOBUS_WR      (IOBUS_WR),
        .IOBUS_RD_DATA (IOBUS_RD_DATA),
        .INTR          (INTR)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        IOBUS_ADDR = a;
        #1;
        d = IOBUS_RD_DATA;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] v);
        IOBUS_ADDR = a;
        IOBUS_OUT  = v;
        IOBUS_WR   = 1'b1;
        tick();
        IOBUS_WR   = 1'b0;
        IOBUS_OUT  = 32'd0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        SRC = 4'd0; IOBUS_ADDR = 32'd0; IOBUS_OUT = 32'd0; IOBUS_WR = 1'b0;
        RST = 1'b1;
        tick(); tick();
        RST = 1'b0;
        n_vec++; if (INTR !== 1'b0) begin n_err++; $display("FAIL rst_intr got=%b exp=0", INTR); end
        rd(c_A_EN, d);   n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL rst_enable got=%h exp=0", d); end
        rd(c_A_PEND, d); n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL rst_pending got=%h exp=0", d); end
        rd(c_A_ID, d);   n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL rst_id got=%h exp=0", d); end
        rd(c_A_STAT, d); n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL rst_status got=%h exp=0", d); end
        wr(c_A_EN, 32'h5);
        rd(c_BASE + 32'h14, d); n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL unmapped_rd got=%h exp=0", d); end
        rd(c_A_EN, d);   n_vec++; if (d !== 32'h5) begin n_err++; $display("FAIL enable_rw got=%h exp=5", d); end
    endtask

    task automatic test_single_source();
        logic [31:0] d;
        wr(c_A_EN, 32'h5);
        SRC = 4'b0100;
        tick();
        SRC = 4'b0000;
        n_vec++; if (INTR !== 1'b0) begin n_err++; $display("FAIL single_intr_c1 got=%b exp=0", INTR); end
        rd(c_A_PEND, d); n_vec++; if (d !== 32'h4) begin n_err++; $display("FAIL single_pend_c1 got=%h exp=4", d); end
        tick();
        n_vec++; if (INTR !== 1'b0) begin n_err++; $display("FAIL single_intr_c2 got=%b exp=0", INTR); end
        rd(c_A_STAT, d); n_vec++; if (d !== 32'h3) begin n_err++; $display("FAIL single_stat_fire got=%h exp=3", d); end
        tick();
        n_vec++; if (INTR !== 1'b1) begin n_err++; $display("FAIL single_intr_c3 got=%b exp=1", INTR); end
        rd(c_A_STAT, d); n_vec++; if (d !== 32'hD) begin n_err++; $display("FAIL single_stat_wait got=%h exp=d", d); end
        rd(c_A_ID, d);   n_vec++; if (d !== 32'h2) begin n_err++; $display("FAIL single_id got=%h exp=2", d); end
        rd(c_A_PEND, d); n_vec++; if (d !== 32'h4) begin n_err++; $display("FAIL single_pend got=%h exp=4", d); end
        tick();
        n_vec++; if (INTR !== 1'b0) begin n_err++; $display("FAIL single_intr_c4 got=%b exp=0", INTR); end
    endtask

    task automatic test_ack_mismatch();
        logic [31:0] d;
        wr(c_A_EN, 32'h0);
        rd(c_A_STAT, d); n_vec++; if (d !== 32'hC) begin n_err++; $display("FAIL en_clr_in_wait got=%h exp=c", d); end
        wr(c_A_EN, 32'h5);
        wr(c_A_ACK, 32'h0);
        rd(c_A_STAT, d); n_vec++; if (d !== 32'hD) begin n_err++; $display("FAIL ack_bad_stat got=%h exp=d", d); end
        rd(c_A_PEND, d); n_vec++; if (d !== 32'h4) begin n_err++; $display("FAIL ack_bad_pend got=%h exp=4", d); end
        wr(c_A_ACK, 32'h2);
        rd(c_A_STAT, d); n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL ack_ok_stat got=%h exp=0", d); end
        rd(c_A_PEND, d); n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL ack_ok_pend got=%h exp=0", d); end
    endtask

    task automatic test_priority();
        logic [31:0] d;
        int k;
        wr(c_A_EN, 32'hF);
        SRC = 4'b1010;
        k = 0;
        while (INTR !== 1'b1 && k < 8) begin tick(); k++; if (k == 1) SRC = 4'b0000; end
        n_vec++; if (k !== 3) begin n_err++; $display("FAIL prio_latency got=%0d exp=3", k); end
        rd(c_A_ID, d);   n_vec++; if (d !== 32'h1) begin n_err++; $display("FAIL prio_id1 got=%h exp=1", d); end
        rd(c_A_PEND, d); n_vec++; if (d !== 32'hA) begin n_err++; $display("FAIL prio_pend got=%h exp=a", d); end
        wr(c_A_ACK, 32'h1);
        rd(c_A_STAT, d); n_vec++; if (d !== 32'h1) begin n_err++; $display("FAIL prio_idle_gap got=%h exp=1", d); end
        tick();
        rd(c_A_STAT, d); n_vec++; if (d !== 32'h3) begin n_err++; $display("FAIL prio_fire2 got=%h exp=3", d); end
        tick();
        n_vec++; if (INTR !== 1'b1) begin n_err++; $display("FAIL prio_intr2 got=%b exp=1", INTR); end
        rd(c_A_ID, d);   n_vec++; if (d !== 32'h3) begin n_err++; $display("FAIL prio_id3 got=%h exp=3", d); end
        wr(c_A_ACK, 32'h3);
        rd(c_A_STAT, d); n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL prio_done got=%h exp=0", d); end
    endtask

    task automatic test_w1c_race();
        logic [31:0] d;
        wr(c_A_EN, 32'h0);
        SRC = 4'b0001;
        wr(c_A_PEND, 32'h1);
        rd(c_A_PEND, d); n_vec++; if (d !== 32'h1) begin n_err++; $display("FAIL w1c_race got=%h exp=1", d); end
        wr(c_A_PEND, 32'h1);
        rd(c_A_PEND, d); n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL w1c_clear got=%h exp=0", d); end
        SRC = 4'b0000;
        tick();
    endtask

    task automatic test_ack_outside_wait();
        logic [31:0] d;
        SRC = 4'b1000;
        tick();
        SRC = 4'b0000;
        wr(c_A_ACK, 32'h3);
        rd(c_A_PEND, d); n_vec++; if (d !== 32'h8) begin n_err++; $display("FAIL ack_idle_pend got=%h exp=8", d); end
        rd(c_A_STAT, d); n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL ack_idle_stat got=%h exp=0", d); end
        wr(c_A_PEND, 32'h8);
    endtask

    task automatic test_reset_in_fire();
        logic [31:0] d;
        wr(c_A_EN, 32'hF);
        SRC = 4'b0010;
        tick();
        SRC = 4'b0000;
        tick();
        rd(c_A_STAT, d); n_vec++; if (d !== 32'h3) begin n_err++; $display("FAIL rfire_stat got=%h exp=3", d); end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        n_vec++; if (INTR !== 1'b0) begin n_err++; $display("FAIL rfire_intr got=%b exp=0", INTR); end
        rd(c_A_STAT, d); n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL rfire_stat0 got=%h exp=0", d); end
    endtask

    task automatic test_reset_in_wait();
        logic [31:0] d;
        int k;
        wr(c_A_EN, 32'hF);
        SRC = 4'b0001;
        k = 0;
        while (INTR !== 1'b1 && k < 8) begin tick(); k++; end
        n_vec++; if (INTR !== 1'b1) begin n_err++; $display("FAIL rwait_intr got=%b exp=1", INTR); end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (INTR !== 1'b0) begin n_err++; $display("FAIL rwait_intr_quiet got=%b exp=0", INTR); end
            tick();
        end
        rd(c_A_EN, d);   n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL rwait_en got=%h exp=0", d); end
        rd(c_A_PEND, d); n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL rwait_held_src got=%h exp=0", d); end
        rd(c_A_ID, d);   n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL rwait_id got=%h exp=0", d); end
        rd(c_A_STAT, d); n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL rwait_stat got=%h exp=0", d); end
        SRC = 4'b0000;
        tick();
        SRC = 4'b0001;
        tick();
        rd(c_A_PEND, d); n_vec++; if (d !== 32'h1) begin n_err++; $display("FAIL rwait_rearm got=%h exp=1", d); end
        wr(c_A_PEND, 32'h1);
        SRC = 4'b0000;
        tick();
    endtask

    task automatic test_timeout();
        logic [31:0] d;
        int k;
        wr(c_A_EN, 32'h4);
        SRC = 4'b0100;
        k = 0;
        while (INTR !== 1'b1 && k < 8) begin tick(); k++; if (k == 1) SRC = 4'b0000; end
        n_vec++; if (INTR !== 1'b1) begin n_err++; $display("FAIL to_first_intr got=%b exp=1", INTR); end
`ifdef OTTER_INTC_TIMEOUT_EN
        for (int r = 0; r < 2; r++) begin
            k = 0;
            do begin tick(); k++; end while (INTR !== 1'b1 && k < 40);
            n_vec++; if (k !== 18) begin n_err++; $display("FAIL to_period got=%0d exp=18", k); end
            rd(c_A_ID, d); n_vec++; if (d !== 32'h2) begin n_err++; $display("FAIL to_id got=%h exp=2", d); end
        end
`else
        k = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (INTR === 1'b1) k++;
        end
        n_vec++; if (k !== 0) begin n_err++; $display("FAIL to_no_repulse got=%0d exp=0", k); end
        rd(c_A_STAT, d); n_vec++; if (d !== 32'hD) begin n_err++; $display("FAIL to_still_wait got=%h exp=d", d); end
`endif
        wr(c_A_ACK, 32'h2);
        rd(c_A_STAT, d); n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL to_ack got=%h exp=0", d); end
    endtask

    initial begin
        test_reset();
        test_single_source();
        test_ack_mismatch();
        test_priority();
        test_w1c_race();
        test_ack_outside_wait();
        test_reset_in_fire();
        test_reset_in_wait();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
